// File: rtl/fp_pkg.sv
// Shared types and constants for the int<->float sequential converter.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PACK  = 2'd2
  } state_e;

  localparam logic OP_CVT_S_W = 1'b0;  // int -> float
  localparam logic OP_CVT_W_S = 1'b1;  // float -> int

  localparam logic [7:0]  EXP_BIAS    = 8'd127;
  localparam logic [7:0]  EXP_INT_TOP = 8'd158;  // exponent of 2^31
  localparam logic [31:0] INT_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;
  localparam logic [31:0] FLT_NEG_2P31 = 32'hCF00_0000;  // exactly -2^31

endpackage

// File: rtl/fp_cvt_shift_step.sv
// One iteration of the normalise (int->float) or denormalise (float->int)
// shift. Purely combinational; the sequencer applies it once per cycle.
module fp_cvt_shift_step
  import fp_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        op,
  input  logic [31:0] mag,
  input  logic [7:0]  exp,
  input  logic [4:0]  rem,
  output logic        pending,
  output logic [31:0] mag_nxt,
  output logic [7:0]  exp_nxt,
  output logic [4:0]  rem_nxt
);

  localparam logic [4:0] STEP_REM = 5'(STEP);
  localparam logic [7:0] STEP_EXP = 8'(STEP);

  logic [4:0] amt;

  // Select the shift amount and produce the next working values.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    pending = 1'b0;
    mag_nxt = mag;
    exp_nxt = exp;
    rem_nxt = rem;
    amt     = '0;
    if (op == OP_CVT_S_W) begin
      // Normalise left until the leading one reaches bit 31.
      pending = ~mag[31] && (mag != '0);
      if (pending) begin
        if (mag[31 -: STEP] == '0) begin
          mag_nxt = mag << STEP;
          exp_nxt = exp - STEP_EXP;
        end else begin
          mag_nxt = mag << 1;
          exp_nxt = exp - 8'd1;
        end
      end
    end else begin
      // Denormalise right by min(STEP, remaining).
      pending = (rem != '0);
      if (pending) begin
        amt     = (rem < STEP_REM) ? rem : STEP_REM;
        mag_nxt = mag >> amt;
        rem_nxt = rem - amt;
      end
    end
  end

endmodule

// File: rtl/fp_cvt_seq.sv
// Multi-cycle IEEE-754 single <-> int32 converter with start/done handshake.
// cvt.s.w truncates by default; define FPCVT_ROUND_EN for round-to-nearest-
// even on the int->float pack. cvt.w.s always truncates.
module fp_cvt_seq
  import fp_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid
);

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [4:0]  rem_q, rem_d;
  logic        inv_q, inv_d;
  logic [31:0] result_q, result_d;
  logic        invalid_q, invalid_d;
  logic        done_q, done_d;

  logic        step_pending;
  logic [31:0] step_mag;
  logic [7:0]  step_exp;
  logic [4:0]  step_rem;

  logic [7:0]  in_exp;
  logic [22:0] in_man;

  logic        round_up;
  logic [23:0] mant_sum;
  logic [7:0]  pack_exp;
  logic [31:0] pack_s;

  assign in_exp = operand[30:23];
  assign in_man = operand[22:0];

  fp_cvt_shift_step #(
    .STEP(STEP)
  ) u_step (
    .op      (op_q),
    .mag     (mag_q),
    .exp     (exp_q),
    .rem     (rem_q),
    .pending (step_pending),
    .mag_nxt (step_mag),
    .exp_nxt (step_exp),
    .rem_nxt (step_rem)
  );

  // Assemble the float word from the normalised magnitude.
  always_comb begin
    round_up = 1'b0;
`ifdef FPCVT_ROUND_EN
    // Guard = mag[7], sticky = |mag[6:0], ties go to even mantissa.
    round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
`endif
    mant_sum = {1'b0, mag_q[30:8]} + {23'd0, round_up};
    pack_exp = exp_q + {7'd0, mant_sum[23]};
    pack_s   = (mag_q == '0) ? 32'd0 : {sign_q, pack_exp, mant_sum[22:0]};
  end

  // Next-state and datapath control for IDLE -> SHIFT -> PACK.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    rem_d     = rem_q;
    inv_d     = inv_q;
    result_d  = result_q;
    invalid_d = invalid_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          op_d    = op;
          exp_d   = EXP_INT_TOP;
          rem_d   = '0;
          inv_d   = 1'b0;
          if (op == OP_CVT_S_W) begin
            sign_d = operand[31];
            mag_d  = operand[31] ? (32'd0 - operand) : operand;
          end else if (in_exp == 8'hFF && in_man != '0) begin
            sign_d = 1'b0;
            mag_d  = INT_MAX;
            inv_d  = 1'b1;
          end else if (in_exp >= EXP_INT_TOP) begin
            // Saturate; -2^31 is the only in-range value in this band.
            sign_d = operand[31];
            mag_d  = operand[31] ? INT_MIN : INT_MAX;
            inv_d  = (operand != FLT_NEG_2P31);
          end else if (in_exp < EXP_BIAS) begin
            sign_d = 1'b0;
            mag_d  = '0;
          end else begin
            sign_d = operand[31];
            mag_d  = {1'b1, in_man, 8'd0};
            rem_d  = 5'(EXP_INT_TOP - in_exp);
          end
        end
      end
      SHIFT: begin
        if (step_pending) begin
          mag_d = step_mag;
          exp_d = step_exp;
          rem_d = step_rem;
        end else begin
          state_d = PACK;
        end
      end
      PACK: begin
        result_d  = (op_q == OP_CVT_W_S) ? (sign_q ? (32'd0 - mag_q) : mag_q)
                                         : pack_s;
        invalid_d = (op_q == OP_CVT_W_S) ? inv_q : 1'b0;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so all flops
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_CVT_S_W;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      rem_q     <= '0;
      inv_q     <= 1'b0;
      result_q  <= '0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      rem_q     <= rem_d;
      inv_q     <= inv_d;
      result_q  <= result_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign result  = result_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_fp_cvt_seq.sv
// Directed bench for fp_cvt_seq: one STEP=1 and one STEP=4 instance.
module tb_fp_cvt_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic        op = 1'b0;
  logic [31:0] operand = '0;
  logic        busy1, done1, invalid1, busy4, done4, invalid4;
  logic [31:0] result1, result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_cvt_seq #(.STEP(1)) u_dut (
    .clk(clk), .rst(rst), .start(start1), .op(op), .operand(operand),
    .busy(busy1), .done(done1), .result(result1), .invalid(invalid1)
  );

  fp_cvt_seq #(.STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .operand(operand),
    .busy(busy4), .done(done4), .result(result4), .invalid(invalid4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one conversion on the selected instance and check result/latency.
  task automatic run(input int sel, input logic op_i, input logic [31:0] opnd,
                     input logic [31:0] exp_res, input logic exp_inv,
                     input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    op = op_i;
    operand = opnd;
    if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    check({tag, " busy"}, 32'((sel == 4) ? busy4 : busy1), 32'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!((sel == 4) ? done4 : done1) && lat < 100);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, (sel == 4) ? result4 : result1, exp_res);
    check({tag, " invalid"}, 32'((sel == 4) ? invalid4 : invalid1), 32'(exp_inv));
  endtask

  initial begin
    int lat;
    logic [31:0] exp_max;

`ifdef FPCVT_ROUND_EN
    exp_max = 32'h4F00_0000;
`else
    exp_max = 32'h4EFF_FFFF;
`endif

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy1), 32'd0);
    check("rst done", 32'(done1), 32'd0);
    check("rst result", result1, 32'd0);
    check("rst invalid", 32'(invalid1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // int -> float, STEP=1 (back-to-back starts in the IDLE cycle after done).
    run(1, 1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33, "s.w 1");
    run(1, 1'b0, 32'hFFFF_FFFB, 32'hC0A0_0000, 1'b0, 31, "s.w -5");
    run(1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 2,  "s.w 0");
    run(1, 1'b0, 32'h7FFF_FFFF, exp_max,       1'b0, 3,  "s.w max");
    run(1, 1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2,  "s.w min");

    // done is a single-cycle pulse and result is held.
    @(posedge clk);
    #1;
    check("done pulse", 32'(done1), 32'd0);
    check("result hold", result1, 32'hCF00_0000);

    // float -> int, STEP=1.
    run(1, 1'b1, 32'hC070_0000, 32'hFFFF_FFFD, 1'b0, 32, "w.s -3.75");
    run(1, 1'b1, 32'h3F00_0000, 32'h0000_0000, 1'b0, 2,  "w.s 0.5");
    run(1, 1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 33, "w.s 1.0");
    run(1, 1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 2,  "w.s 2^31");
    run(1, 1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 2,  "w.s -2^31");
    run(1, 1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 2,  "w.s nan");
    run(1, 1'b1, 32'hFF80_0000, 32'h8000_0000, 1'b1, 2,  "w.s -inf");

    // STEP=4 instance.
    run(4, 1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 12, "step4 s.w 1");
    run(4, 1'b1, 32'hC070_0000, 32'hFFFF_FFFD, 1'b0, 10, "step4 w.s -3.75");

    // A second start while busy is ignored.
    @(negedge clk);
    op = 1'b0;
    operand = 32'h0000_0001;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    op = 1'b1;
    operand = 32'h4F00_0000;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    lat = 4;
    while (!done1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignore latency", 32'(lat), 32'd33);
    check("ignore result", result1, 32'h3F80_0000);
    check("ignore invalid", 32'(invalid1), 32'd0);

    // Reset mid-SHIFT aborts immediately.
    @(negedge clk);
    op = 1'b0;
    operand = 32'h0000_0001;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre-rst busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    #1;
    check("mid-rst busy", 32'(busy1), 32'd0);
    check("mid-rst done", 32'(done1), 32'd0);
    check("mid-rst result", result1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh operation after reset.
    run(1, 1'b0, 32'hFFFF_FFFB, 32'hC0A0_0000, 1'b0, 31, "post-rst s.w -5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_cvt_seq.md
Name: fp_cvt_seq

Overview:
Multi-cycle converter between IEEE-754 single precision and 32-bit two's-complement integer: cvt.s.w (int→float) and cvt.w.s (float→int, truncating).
Provides the int↔float encode/decode path that the combinational FPU add/compare unit lacks.
Sits beside the FPU in EX and is started by the MIPS control path with a start/done handshake.
Normalization and denormalization are iterative shifts, STEP bits per cycle.

Parameters:
STEP, 1, max shift distance per cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  1  0 = cvt.s.w (int→float), 1 = cvt.w.s (float→int)
operand  input  32  int or float source, captured with start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse; result valid from this cycle
result  output  32  converted value, held until next accepted start
invalid  output  1  float→int overflow or NaN, valid with done

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, result=0, invalid=0. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, SHIFT, PACK.
- IDLE, start=1: capture operand/op into working regs, go to SHIFT. Start outside IDLE is ignored.
- SHIFT: one step per edge. Go to PACK when no shift remains, including zero steps.
- PACK: register result/invalid, done=1 for that one cycle, return to IDLE.
- A start may be sampled in the IDLE cycle that follows done.
- Latency: done is high N+2 edges after the start-sampling edge, where N = number of shift steps.
- Int→float load: sign=operand[31], mag=|operand| as unsigned 32-bit (0x80000000 stays 0x80000000), exp=158.
- Int→float, mag=0: N=0, result=0x00000000.
- Int→float SHIFT, while mag[31]=0: if the top STEP bits of mag are all zero, shift left STEP and exp-=STEP; else shift left 1 and exp-=1.
- Int→float PACK: result={sign, exp, mag[30:8]}; low 8 bits truncated.
- Float→int: exp field e, mantissa m. Denormals are treated as zero.
- Float→int, e<127: result=0, N=0.
- Float→int, e=255 with m≠0 (NaN): result=0x7FFFFFFF, invalid=1.
- Float→int, e≥158 (not NaN): result=0x7FFFFFFF if positive, 0x80000000 if negative. invalid=1, except exactly 0xCF000000, which gives 0x80000000 with invalid=0.
- Float→int, 127≤e≤157: work={1,m,8'b0}, remaining=158−e.
- Float→int SHIFT: shift right by min(STEP, remaining) per edge. N=ceil((158−e)/STEP).
- Float→int PACK: result = sign ? −work : work.
- invalid is 0 for every int→float conversion.

Optional Feature:
FPCVT_ROUND_EN
- Defined: int→float PACK rounds to nearest-even. Guard=mag[7], sticky=|mag[6:0], lsb=mag[8].
- Defined, rounding up: increment the mantissa. On mantissa carry-out, mantissa=0 and exp+=1.
- Defined, latency: unchanged, rounding happens inside PACK.
- Undefined: truncation as above.
- Float→int always truncates, with or without the macro.

Decomposition:
- Package fp_pkg holds: state enum {IDLE,SHIFT,PACK}; OP_CVT_S_W=0 and OP_CVT_W_S=1; EXP_BIAS=127; EXP_INT_TOP=158; INT_MAX=0x7FFFFFFF; INT_MIN=0x80000000.
- One sub-module is natural: fp_cvt_shift_step. It is combinational, one shift step with amount selection per STEP; the FSM instantiates it once.

Test Plan:
- STEP=1, op=0, operand=0x00000001 → result 0x3F800000, invalid=0, N=31, done 33 edges after start.
- op=0, operand=0xFFFFFFFB (−5) → 0xC0A00000. op=0, operand=0 → 0x00000000, done 2 edges after start.
- op=0, operand=0x7FFFFFFF → 0x4EFFFFFF without macro; 0x4F000000 with FPCVT_ROUND_EN.
- op=1 cases:
  - 0xC0700000 (−3.75) → 0xFFFFFFFD.
  - 0x3F000000 → 0x00000000.
  - 0x4F000000 → 0x7FFFFFFF, invalid=1.
  - 0xCF000000 → 0x80000000, invalid=0.
  - 0x7FC00000 → 0x7FFFFFFF, invalid=1.
- STEP=4, op=0, operand=0x00000001 → 0x3F800000 after N=10 (7×4 + 3×1 shifts), done 12 edges after start.
- Control cases:
  - A second start while busy is ignored; the first result is unchanged.
  - rst asserted mid-SHIFT gives busy=0, done=0, result=0 immediately.
  - A new start after reset completes correctly.
